// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive FIFO drain port (head word, valid/ready, fill level)
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int COUNT_W   = 3
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic [COUNT_W-1:0]   fifo_count;
    modport master (output data_out, data_valid, fifo_count, input data_ready);
    modport slave (input data_out, data_valid, fifo_count, output data_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with small output FIFO; define UART_RX_PARITY_EN to expect and check a parity bit
module uart_rx_fifo #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 4,
    parameter int PARITY_ODD      = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx,
    uart_rx_fifo_if.master    bus,
    output logic              framing_error,
    output logic              overrun,
    output logic              parity_error
);
    localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int TW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic                 rx_m, rx_s, rx_prev;
    logic [TW-1:0]        timer;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_bad;
    logic                 expire, last_stop, stop_ok, parity_ok, push, pop, full, wr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;

    assign expire    = timer == '0;
    assign last_stop = state == STOP && expire && bit_idx == 4'(STOP_BITS - 1);
    assign stop_ok   = !stop_bad && rx_s;
    assign push      = last_stop && stop_ok && parity_ok;
    assign full      = count == CW'(FIFO_DEPTH);
    assign pop       = bus.data_valid && bus.data_ready;
    assign wr        = push && (!full || pop);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign parity_ok = par_bit == (^shift ^ (PARITY_ODD != 0));
    // Parity mismatch reported only on frames whose stop bits were good.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) parity_error <= 1'b0;
        else parity_error <= last_stop && stop_ok && !parity_ok;
`else
    assign parity_ok    = 1'b1;
    assign parity_error = 1'b0;
`endif

    // Two-flop synchroniser plus one delayed copy for start-edge detection; idle-high reset.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) {rx_m, rx_s, rx_prev} <= 3'b111;
        else {rx_m, rx_s, rx_prev} <= {rx, rx_m, rx_s};

    // Frame state machine: timer counts down to the next mid-bit sample point.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            stop_bad      <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
`endif
        end else begin
            framing_error <= last_stop && !stop_ok;
            timer         <= expire ? TW'(CPB - 1) : timer - 1'b1;
            case (state)
                IDLE: begin
                    bit_idx  <= '0;
                    stop_bad <= 1'b0;
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        timer <= TW'(CPB / 2 - 1);
                    end
                end
                START: if (expire) state <= rx_s ? IDLE : DATA;
                DATA: if (expire) begin
                    shift   <= {rx_s, shift[DATA_BITS-1:1]};
                    bit_idx <= bit_idx == 4'(DATA_BITS - 1) ? '0 : bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 4'(DATA_BITS - 1)) state <= PARITY;
`else
                    if (bit_idx == 4'(DATA_BITS - 1)) state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (expire) begin
                    par_bit <= rx_s;
                    state   <= STOP;
                end
`endif
                STOP: if (expire) begin
                    stop_bad <= stop_bad || !rx_s;
                    bit_idx  <= bit_idx + 1'b1;
                    if (last_stop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

    // FIFO pointers and count; a push into a full FIFO without a pop is dropped and flagged.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            wr_ptr  <= wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count   <= count + CW'(wr) - CW'(pop);
        end

    // FIFO storage needs no reset: data_out is masked while empty.
    always_ff @(posedge clock)
        if (wr) mem[wr_ptr] <= shift;

    assign bus.data_valid = count != '0;
    assign bus.data_out   = bus.data_valid ? mem[rd_ptr] : '0;
    assign bus.fifo_count = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized frames scored against a queue model of the receive FIFO and error pulses
module tb_uart_rx_fifo;
    localparam int CF  = 1000000;
    localparam int BR  = 100000;
    localparam int DB  = 8;
    localparam int SB  = 1;
    localparam int FD  = 4;
    localparam int PO  = 0;
    localparam int CPB = CF / BR;
    localparam int CW  = $clog2(FD) + 1;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic framing_error, overrun, parity_error;

    uart_rx_fifo_if #(.DATA_BITS(DB), .COUNT_W(CW)) bus ();

    uart_rx_fifo #(
        .CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .DATA_BITS(DB),
        .STOP_BITS(SB), .FIFO_DEPTH(FD), .PARITY_ODD(PO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .rx(rx), .bus(bus),
        .framing_error(framing_error), .overrun(overrun), .parity_error(parity_error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    logic [DB-1:0] exp_q[$];
    byte ev_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted word and every error pulse must match the head of its queue.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.data_valid && bus.data_ready)
                check("data_out", int'(bus.data_out), exp_q.size() != 0 ? int'(exp_q.pop_front()) : -1);
            if (framing_error) check("pulse", int'("F"), ev_q.size() != 0 ? int'(ev_q.pop_front()) : 0);
            if (overrun)       check("pulse", int'("O"), ev_q.size() != 0 ? int'(ev_q.pop_front()) : 0);
            if (parity_error)  check("pulse", int'("P"), ev_q.size() != 0 ? int'(ev_q.pop_front()) : 0);
        end
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input bit bad_stop, input bit bad_par, input int low_hold);
        repeat (FD + 2) @(negedge clock);
        if (bad_stop) ev_q.push_back("F");
        else if (PAR_EN && bad_par) ev_q.push_back("P");
        else if (exp_q.size() == FD) ev_q.push_back("O");
        else exp_q.push_back(d);
        bit_out(1'b0);
        for (int i = 0; i < DB; i++) bit_out(d[i]);
        if (PAR_EN) bit_out(^d ^ 1'(PO) ^ bad_par);
        for (int i = 0; i < SB; i++) bit_out(!bad_stop);
        if (bad_stop) repeat (low_hold) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check("fifo_count", int'(bus.fifo_count), exp_q.size());
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        repeat (len) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("glitch_count", int'(bus.fifo_count), exp_q.size());
    endtask

    task automatic drain();
        int budget;
        bus.data_ready = 1'b1;
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        bus.data_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_valid", int'(bus.data_valid), 0);
        check("rst_count", int'(bus.fifo_count), 0);
        check("rst_data", int'(bus.data_out), 0);
        check("rst_errs", int'({framing_error, overrun, parity_error}), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        send_frame(8'h5A, 0, 0, 0);
        glitch(3);
        send_frame(8'h33, 0, 0, 0);
        send_frame(8'hA5, 1, 0, 30);

        bus.data_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0);
        check("full_count", int'(bus.fifo_count), FD);
        drain();

        send_frame(8'h03, 0, 1, 0);
        send_frame(8'h03, 0, 0, 0);

        bus.data_ready = 1'b0;
        send_frame(8'h77, 0, 0, 0);
        bit_out(1'b0);
        for (int i = 0; i < 3; i++) bit_out(1'b1);
        repeat (CPB / 2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", int'(bus.data_valid), 0);
        check("midrst_count", int'(bus.fifo_count), 0);
        check("midrst_data", int'(bus.data_out), 0);
        check("midrst_errs", int'({framing_error, overrun, parity_error}), 0);
        exp_q.delete();
        ev_q.delete();
        rx = 1'b1;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        bus.data_ready = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("post_rst_errs", int'({framing_error, overrun, parity_error}), 0);
        send_frame(8'hC3, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            bus.data_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 7) == 0) glitch($urandom_range(1, 3));
            send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 30));
        end

        drain();
        repeat (10) @(negedge clock);
        check("events_left", ev_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
